// File: rtl/stack_param_if.sv
// Operand-stack command/status bundle between the control unit (master) and stack_param (slave).
// Same-cycle wiring only; the busy/done handshake is carried inside the bundle.
interface stack_param_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 16
);
  logic             trigger;
  logic [1:0]       op;
  logic [WIDTH-1:0] write_value;
  logic [WIDTH-1:0] read_value;
  logic             done_out;
  logic             error;
  logic             busy;
  logic             empty;
  logic             full;
  logic [AW:0]      count;

  modport master (
    output trigger, op, write_value,
    input  read_value, done_out, error, busy, empty, full, count
  );

  modport slave (
    input  trigger, op, write_value,
    output read_value, done_out, error, busy, empty, full, count
  );
endinterface

// File: rtl/stack_param.sv
// LIFO operand stack on one sync block RAM; done_out 2 edges after accept (SWAP: 5), one op in flight.
// STACK_SWAP_EN enables the multi-cycle SWAP of the top two entries; otherwise op 11 is rejected.
module stack_param #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 65536
) (
  input  logic          clk,
  input  logic          rst,
  stack_param_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE     = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PEEK = 2'b10;

`ifdef STACK_SWAP_EN
  localparam logic [1:0]  OP_SWAP = 2'b11;
  localparam logic [AW:0] TWO     = (AW+1)'(2);
  typedef enum logic [2:0] {IDLE, EXEC, S_RD1, S_RD2, S_WR1, S_WR2} state_t;
`else
  typedef enum logic [2:0] {IDLE, EXEC} state_t;
`endif

  state_t           state;
  logic [AW:0]      sp;
  logic [1:0]       op_q;
  logic             err_q;
  logic [WIDTH-1:0] read_value_q;
  logic             done_q, error_q, busy_q, empty_q, full_q;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] ram_q;
  logic             ram_we;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_wdata;
  logic [AW:0]      sp_inc, sp_dec;

  assign sp_inc = sp + ONE;
  assign sp_dec = sp - ONE;

`ifdef STACK_SWAP_EN
  logic [WIDTH-1:0] tmp_a, tmp_b;
  logic [AW:0]      sp_dec2;
  assign sp_dec2 = sp - TWO;
`endif

  // Single RAM port: the FSM state decides whether this cycle reads or writes.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = sp_dec[AW-1:0];
    ram_wdata = bus.write_value;
    if (state == IDLE && bus.trigger && bus.op == OP_PUSH && !full_q) begin
      ram_we   = 1'b1;
      ram_addr = sp[AW-1:0];
    end
`ifdef STACK_SWAP_EN
    if (state == S_RD1) ram_addr = sp_dec2[AW-1:0];
    if (state == S_WR1) begin
      ram_we    = 1'b1;
      ram_wdata = tmp_b;
    end
    if (state == S_WR2) begin
      ram_we    = 1'b1;
      ram_addr  = sp_dec2[AW-1:0];
      ram_wdata = tmp_a;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_q <= mem[ram_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sp           <= '0;
      op_q         <= OP_PUSH;
      err_q        <= 1'b0;
      read_value_q <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      busy_q       <= 1'b0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
`ifdef STACK_SWAP_EN
      tmp_a        <= '0;
      tmp_b        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done_q  <= 1'b0;
          error_q <= 1'b0;
          busy_q  <= bus.trigger;
          if (bus.trigger) begin
            op_q  <= bus.op;
            state <= EXEC;
            case (bus.op)
              OP_PUSH:         err_q <= full_q;
              OP_POP, OP_PEEK: err_q <= empty_q;
              default: begin
`ifdef STACK_SWAP_EN
                err_q <= (sp < TWO);
                if (sp >= TWO) state <= S_RD1;
`else
                err_q <= 1'b1;
`endif
              end
            endcase
          end
        end
        EXEC: begin
          done_q  <= 1'b1;
          error_q <= err_q;
          state   <= IDLE;
          if (!err_q) begin
            case (op_q)
              OP_PUSH: begin
                sp      <= sp_inc;
                empty_q <= 1'b0;
                full_q  <= (sp_inc == DEPTH_V);
              end
              OP_POP: begin
                read_value_q <= ram_q;
                sp           <= sp_dec;
                full_q       <= 1'b0;
                empty_q      <= (sp == ONE);
              end
              OP_PEEK: read_value_q <= ram_q;
              default: ;
            endcase
          end
        end
`ifdef STACK_SWAP_EN
        S_RD1: begin
          tmp_a <= ram_q;
          state <= S_RD2;
        end
        S_RD2: begin
          tmp_b <= ram_q;
          state <= S_WR1;
        end
        S_WR1: state <= S_WR2;
        S_WR2: begin
          read_value_q <= tmp_b;
          done_q       <= 1'b1;
          error_q      <= 1'b0;
          state        <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.read_value = read_value_q;
  assign bus.done_out   = done_q;
  assign bus.error      = error_q;
  assign bus.busy       = busy_q;
  assign bus.empty      = empty_q;
  assign bus.full       = full_q;
  assign bus.count      = sp;
endmodule
